// File: rtl/pipeline_ctrl.sv
// Hazard and stall sequencer for the five-stage core.
// Drives the PC and stage-register enables/flushes; runs a memory watchdog and perf counters.
module pipeline_ctrl #(
  parameter int REG_SEL_W    = 5,
  parameter int MAX_MEM_WAIT = 255,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_SEL_W-1:0] dec_reg_1_sel,
  input  logic [REG_SEL_W-1:0] dec_reg_2_sel,
  input  logic                 dec_reg_1_used,
  input  logic                 dec_reg_2_used,
  input  logic                 ex_mem_en,
  input  logic                 ex_mem_wrt,
  input  logic                 ex_reg_wrt_en,
  input  logic [REG_SEL_W-1:0] ex_reg_wrt_sel,
  input  logic                 ex_redirect,
  input  logic                 imem_ready,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 pc_we,
  output logic                 FeDe_we,
  output logic                 DeEx_we,
  output logic                 ExMe_we,
  output logic                 MeWb_we,
  output logic                 FeDe_flush,
  output logic                 DeEx_flush,
  output logic [1:0]           ctrl_state,
  output logic                 mem_timeout,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     redirect_cnt
);

  localparam int WW = (MAX_MEM_WAIT > 1) ? $clog2(MAX_MEM_WAIT) : 1;
  localparam logic [WW-1:0] LAST = WW'(MAX_MEM_WAIT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          lu, ms, ms_eff, eval;
  logic          sel_ms, sel_rd, sel_lu, sel_if, sel_go;

  assign ms = dmem_req & ~dmem_ready;
  assign lu = ex_mem_en & ~ex_mem_wrt & ex_reg_wrt_en
            & (ex_reg_wrt_sel != '0)
            & ((dec_reg_1_used & (dec_reg_1_sel == ex_reg_wrt_sel))
             | (dec_reg_2_used & (dec_reg_2_sel == ex_reg_wrt_sel)));

  // One-hot selection of the winning condition in priority order
  assign sel_ms = eval & ms_eff;
  assign sel_rd = eval & ~ms_eff & ex_redirect;
  assign sel_lu = eval & ~ms_eff & ~ex_redirect & lu;
  assign sel_if = eval & ~ms_eff & ~ex_redirect & ~lu & ~imem_ready;
  assign sel_go = eval & ~ms_eff & ~ex_redirect & ~lu & imem_ready;

  always_comb begin
    state_nxt  = state;
    wait_nxt   = wait_cnt;
    eval       = 1'b0;
    ms_eff     = 1'b0;
    pc_we      = 1'b0;
    FeDe_we    = 1'b0;
    DeEx_we    = 1'b0;
    ExMe_we    = 1'b0;
    MeWb_we    = 1'b0;
    FeDe_flush = 1'b0;
    DeEx_flush = 1'b0;
    case (state)
      RUN: begin
        eval   = 1'b1;
        ms_eff = ms;
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          eval      = 1'b1;
          state_nxt = RUN;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
          if (wait_cnt == LAST) state_nxt = ERROR;
        end
      end
      ERROR: ;
      default: state_nxt = RUN;
    endcase
    unique case (1'b1)
      sel_ms: begin
        state_nxt = MEM_WAIT;
        wait_nxt  = '0;
      end
      sel_rd: begin
        {pc_we, FeDe_we, DeEx_we, ExMe_we, MeWb_we} = '1;
        FeDe_flush = 1'b1;
        DeEx_flush = 1'b1;
      end
      sel_lu: begin
        {DeEx_we, ExMe_we, MeWb_we} = '1;
        DeEx_flush = 1'b1;
      end
      sel_if: begin
        {FeDe_we, DeEx_we, ExMe_we, MeWb_we} = '1;
        FeDe_flush = 1'b1;
      end
      sel_go: {pc_we, FeDe_we, DeEx_we, ExMe_we, MeWb_we} = '1;
      default: ;
    endcase
    if (!rst_n) begin
      {pc_we, FeDe_we, DeEx_we, ExMe_we, MeWb_we} = '0;
      FeDe_flush = 1'b0;
      DeEx_flush = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state_nxt == ERROR) mem_timeout <= 1'b1;
      if (!pc_we && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (sel_rd && redirect_cnt != '1) redirect_cnt <= redirect_cnt + 1'b1;
    end
  end

  assign ctrl_state = state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a default instance plus one with
// a short watchdog and 2-bit counters, both fed identical stimulus.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] dec_reg_1_sel, dec_reg_2_sel, ex_reg_wrt_sel;
  logic       dec_reg_1_used, dec_reg_2_used;
  logic       ex_mem_en, ex_mem_wrt, ex_reg_wrt_en;
  logic       ex_redirect, imem_ready, dmem_req, dmem_ready;

  logic        d_pc, d_fd, d_de, d_em, d_mw, d_ff, d_df, d_to;
  logic [1:0]  d_st;
  logic [15:0] d_sc, d_rc;
  logic        s_pc, s_fd, s_de, s_em, s_mw, s_ff, s_df, s_to;
  logic [1:0]  s_st;
  logic [1:0]  s_sc, s_rc;

  int errors = 0;
  int checks = 0;

  wire [6:0] d_we = {d_pc, d_fd, d_de, d_em, d_mw, d_ff, d_df};
  wire [6:0] s_we = {s_pc, s_fd, s_de, s_em, s_mw, s_ff, s_df};

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .dec_reg_1_sel(dec_reg_1_sel), .dec_reg_2_sel(dec_reg_2_sel),
    .dec_reg_1_used(dec_reg_1_used), .dec_reg_2_used(dec_reg_2_used),
    .ex_mem_en(ex_mem_en), .ex_mem_wrt(ex_mem_wrt),
    .ex_reg_wrt_en(ex_reg_wrt_en), .ex_reg_wrt_sel(ex_reg_wrt_sel),
    .ex_redirect(ex_redirect), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_we(d_pc), .FeDe_we(d_fd), .DeEx_we(d_de), .ExMe_we(d_em),
    .MeWb_we(d_mw), .FeDe_flush(d_ff), .DeEx_flush(d_df),
    .ctrl_state(d_st), .mem_timeout(d_to),
    .stall_cnt(d_sc), .redirect_cnt(d_rc)
  );

  pipeline_ctrl #(.MAX_MEM_WAIT(3), .CNT_W(2)) sml (
    .clk(clk), .rst_n(rst_n),
    .dec_reg_1_sel(dec_reg_1_sel), .dec_reg_2_sel(dec_reg_2_sel),
    .dec_reg_1_used(dec_reg_1_used), .dec_reg_2_used(dec_reg_2_used),
    .ex_mem_en(ex_mem_en), .ex_mem_wrt(ex_mem_wrt),
    .ex_reg_wrt_en(ex_reg_wrt_en), .ex_reg_wrt_sel(ex_reg_wrt_sel),
    .ex_redirect(ex_redirect), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_we(s_pc), .FeDe_we(s_fd), .DeEx_we(s_de), .ExMe_we(s_em),
    .MeWb_we(s_mw), .FeDe_flush(s_ff), .DeEx_flush(s_df),
    .ctrl_state(s_st), .mem_timeout(s_to),
    .stall_cnt(s_sc), .redirect_cnt(s_rc)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    dec_reg_1_sel = 5'd0; dec_reg_2_sel = 5'd0;
    dec_reg_1_used = 1'b0; dec_reg_2_used = 1'b0;
    ex_mem_en = 1'b0; ex_mem_wrt = 1'b0;
    ex_reg_wrt_en = 1'b0; ex_reg_wrt_sel = 5'd0;
    ex_redirect = 1'b0; imem_ready = 1'b1;
    dmem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  // Load into r3 in Execute; Decode reads r5 as reg_1 and r3 as reg_2
  task automatic load_use();
    ex_mem_en = 1'b1; ex_mem_wrt = 1'b0;
    ex_reg_wrt_en = 1'b1; ex_reg_wrt_sel = 5'd3;
    dec_reg_1_sel = 5'd5; dec_reg_1_used = 1'b1;
    dec_reg_2_sel = 5'd3; dec_reg_2_used = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    chk("reset_we", 32'(d_we), 32'b0000000);
    chk("reset_state", 32'(d_st), 32'd0);
    chk("reset_cnts", 32'({d_sc, d_rc, d_to}), 32'd0);
    rst_n = 1'b1;

    #1;
    chk("run_idle_we", 32'(d_we), 32'b1111100);
    tick();

    load_use();
    #1;
    chk("lu_we", 32'(d_we), 32'b0011101);
    tick();
    idle();
    #1;
    chk("lu_stall_cnt", 32'(d_sc), 32'd1);
    chk("lu_after_we", 32'(d_we), 32'b1111100);
    tick();

    load_use();
    ex_reg_wrt_sel = 5'd0;
    dec_reg_2_sel = 5'd0;
    #1;
    chk("lu_r0_we", 32'(d_we), 32'b1111100);
    tick();

    load_use();
    ex_redirect = 1'b1;
    #1;
    chk("rd_lu_we", 32'(d_we), 32'b1111111);
    tick();
    idle();
    #1;
    chk("rd_lu_rcnt", 32'(d_rc), 32'd1);
    chk("rd_lu_scnt", 32'(d_sc), 32'd1);

    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("if_wait_we", 32'(d_we), 32'b0111110);
      tick();
    end
    imem_ready = 1'b1;
    #1;
    chk("if_wait_scnt", 32'(d_sc), 32'd3);
    tick();

    dmem_req = 1'b1;
    dmem_ready = 1'b0;
    ex_redirect = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ms_we", 32'(d_we), 32'b0000000);
      chk("ms_state", 32'(d_st), (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    chk("ms_rel_state", 32'(d_st), 32'd1);
    chk("ms_rel_we", 32'(d_we), 32'b1111111);
    chk("ms_rel_scnt", 32'(d_sc), 32'd7);
    chk("to_state", 32'(s_st), 32'd2);
    chk("to_flag", 32'(s_to), 32'd1);
    chk("to_we", 32'(s_we), 32'b0000000);
    tick();
    chk("ms_done_state", 32'(d_st), 32'd0);
    chk("ms_done_rcnt", 32'(d_rc), 32'd2);
    chk("ms_done_to", 32'(d_to), 32'd0);

    idle();
    dmem_req = 1'b1;
    #1;
    chk("dm_fast_we", 32'(d_we), 32'b1111100);
    chk("err_hold_we", 32'(s_we), 32'b0000000);
    tick();
    chk("dm_fast_state", 32'(d_st), 32'd0);
    chk("err_hold_state", 32'(s_st), 32'd2);

    idle();
    rst_n = 1'b0;
    #1;
    chk("rst2_we", 32'(s_we), 32'b0000000);
    chk("rst2_state", 32'(s_st), 32'd0);
    chk("rst2_cnts", 32'({s_sc, s_rc, s_to}), 32'd0);
    chk("rst2_dcnts", 32'({d_sc, d_rc}), 32'd0);
    rst_n = 1'b1;
    tick();

    load_use();
    for (int i = 0; i < 5; i++) tick();
    idle();
    #1;
    chk("sat_scnt", 32'(s_sc), 32'd3);
    chk("sat_dcnt", 32'(d_sc), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
